// File: rtl/peg_l2_rs_rmii_tx_if.sv
// peg_l2_rs_rmii_tx_if: MAC TX packet word bus (valid/ready with sop/eop framing).
//   master (MAC): drives pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_eop_bytes; receives pkt_ready
//   slave  (RS) : the reverse
interface peg_l2_rs_rmii_tx_if #(
  parameter int PKT_DATA_W = 64
);
  localparam int EBW = $clog2(PKT_DATA_W / 8);
  logic                  pkt_valid;
  logic                  pkt_sop;
  logic                  pkt_eop;
  logic [PKT_DATA_W-1:0] pkt_data;
  logic [EBW-1:0]        pkt_eop_bytes;
  logic                  pkt_ready;
  modport master (output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_eop_bytes, input pkt_ready);
  modport slave  (input pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_eop_bytes, output pkt_ready);
endinterface

// File: rtl/peg_l2_rs_rmii_tx.sv
// peg_l2_rs_rmii_tx: RMII transmit reconciliation; preamble/SFD, LSB-dibit-first serialiser, IFG, 100/10 Mbps.
//   rmii_ref_clk, rst_n (async, active-low) ; config_rs_mii_speed_100_n_10 (1 = 100 Mbps, latched at sop)
//   pkt (slave)  : packet words from MAC TX, byte0 = [7:0] first on wire
//   rmii_tx_en, rmii_txd : registered RMII outputs ; tx_underrun : one-cycle pulse on mid-packet starvation
//   `PEG_L2_RS_RMII_TX_STATS_EN adds tx_pkt_cntr[15:0], count of fully transmitted packets
module peg_l2_rs_rmii_tx #(
  parameter int PKT_DATA_W = 64,
  parameter int IFG_BYTES  = 12
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst_n,
  input  logic                  config_rs_mii_speed_100_n_10,
  peg_l2_rs_rmii_tx_if.slave    pkt,
  output logic                  rmii_tx_en,
  output logic [1:0]            rmii_txd,
`ifdef PEG_L2_RS_RMII_TX_STATS_EN
  output logic [15:0]           tx_pkt_cntr,
`endif
  output logic                  tx_underrun
);
  localparam logic [1:0] PREAMBLE_VALUE = 2'b01;
  localparam logic [1:0] SFD_VALUE      = 2'b11;
  localparam int EBW   = $clog2(PKT_DATA_W / 8);
  localparam int CW    = $clog2(PKT_DATA_W / 2 + 1);
  localparam int IFG_T = IFG_BYTES * 4;
  localparam int IW    = $clog2(IFG_T + 1);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DRAIN, IFG} state_t;
  state_t                state;
  logic                  spd100;
  logic [3:0]            div;
  logic [4:0]            pre_cnt;
  logic [CW-1:0]         dib_cnt;
  logic [IW-1:0]         ifg_cnt;
  logic [PKT_DATA_W-1:0] sr;
  logic                  eop_l;
  logic [EBW-1:0]        eop_bytes_l;
  logic                  tick;
  logic [CW-1:0]         n_dib;
  logic                  last_launch;
  logic                  accept;
  assign tick        = spd100 || div == 4'd9;
  assign n_dib       = (eop_l && eop_bytes_l != '0) ? CW'({eop_bytes_l, 2'b00}) : CW'(PKT_DATA_W / 2);
  // dib_cnt counts dibits already launched from the current word
  assign last_launch = state == DATA && tick && dib_cnt == n_dib - CW'(1);
  assign pkt.pkt_ready = state == IDLE || state == DRAIN || (last_launch && !eop_l);
  assign accept      = pkt.pkt_valid && pkt.pkt_ready;
  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spd100      <= 1'b1;
      div         <= '0;
      pre_cnt     <= '0;
      dib_cnt     <= '0;
      ifg_cnt     <= '0;
      sr          <= '0;
      eop_l       <= 1'b0;
      eop_bytes_l <= '0;
      rmii_tx_en  <= 1'b0;
      rmii_txd    <= 2'b00;
      tx_underrun <= 1'b0;
`ifdef PEG_L2_RS_RMII_TX_STATS_EN
      tx_pkt_cntr <= '0;
`endif
    end else begin
      tx_underrun <= 1'b0;
      div <= (state == IDLE || spd100 || div == 4'd9) ? 4'd0 : div + 4'd1;
      case (state)
        IDLE: if (accept && pkt.pkt_sop) begin
          sr          <= pkt.pkt_data;
          eop_l       <= pkt.pkt_eop;
          eop_bytes_l <= pkt.pkt_eop_bytes;
          spd100      <= config_rs_mii_speed_100_n_10;
          pre_cnt     <= '0;
          rmii_tx_en  <= 1'b1;
          rmii_txd    <= PREAMBLE_VALUE;
          state       <= PREAMBLE;
        end
        PREAMBLE: if (tick) begin
          if (pre_cnt == 5'd31) begin
            rmii_txd <= sr[1:0];
            sr       <= sr >> 2;
            dib_cnt  <= CW'(1);
            state    <= DATA;
          end else begin
            rmii_txd <= pre_cnt == 5'd30 ? SFD_VALUE : PREAMBLE_VALUE;
            pre_cnt  <= pre_cnt + 5'd1;
          end
        end
        DATA: if (tick) begin
          if (dib_cnt == n_dib) begin
            rmii_tx_en  <= 1'b0;
            rmii_txd    <= 2'b00;
            ifg_cnt     <= '0;
            tx_underrun <= !eop_l;
            state       <= eop_l ? IFG : DRAIN;
`ifdef PEG_L2_RS_RMII_TX_STATS_EN
            if (eop_l) tx_pkt_cntr <= tx_pkt_cntr + 16'd1;
`endif
          end else begin
            rmii_txd <= sr[1:0];
            sr       <= sr >> 2;
            dib_cnt  <= dib_cnt + CW'(1);
            // next word is taken while its predecessor's final dibit goes out, so no gap dibit
            if (accept) begin
              sr          <= pkt.pkt_data;
              eop_l       <= pkt.pkt_eop;
              eop_bytes_l <= pkt.pkt_eop_bytes;
              dib_cnt     <= '0;
            end
          end
        end
        DRAIN: if (accept && pkt.pkt_eop) begin
          ifg_cnt <= '0;
          div     <= '0;
          state   <= IFG;
        end
        IFG: if (tick) begin
          if (ifg_cnt == IW'(IFG_T - 1)) state <= IDLE;
          else ifg_cnt <= ifg_cnt + IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
